crossbar_dispatch: RTL and testbench

Output-side consumer of the router's per-port mux selects (control_x/y/local: 00 none, 01 data x, 10 data y, 11 data local).
- Per output port, pops the selected input FIFO (first-word-fall-through) and registers the flit.
- Presents the flit downstream on a valid/ready link.
- Flags a port as failed on a stuck-ready timeout; fail[2:0] feeds back to the transport control logic.

---
 rtl/crossbar_dispatch_if.sv | 37 +++
 rtl/crossbar_dispatch.sv | 147 ++++++++++++++
 tb/tb_crossbar_dispatch.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/crossbar_dispatch_if.sv
// Bundle of the dispatch stage's per-port select, input-FIFO, output-link
// and failure signals. The slave modport is the dispatch block itself; the
// master modport is everything around it (router control, FIFOs, downstream).
interface crossbar_dispatch_if #(
  parameter int DATA_W = 40
);
  logic [1:0]        control_x, control_y, control_local;
  logic [DATA_W-1:0] din_x, din_y, din_local;
  logic              empty_x, empty_y, empty_local;
  logic              rd_en_x, rd_en_y, rd_en_local;
  logic [DATA_W-1:0] dout_x, dout_y, dout_local;
  logic              valid_x, valid_y, valid_local;
  logic              ready_x, ready_y, ready_local;
  logic [2:0]        fail;

  modport master (
    output control_x, control_y, control_local,
    output din_x, din_y, din_local,
    output empty_x, empty_y, empty_local,
    output ready_x, ready_y, ready_local,
    input  rd_en_x, rd_en_y, rd_en_local,
    input  dout_x, dout_y, dout_local,
    input  valid_x, valid_y, valid_local,
    input  fail
  );

  modport slave (
    input  control_x, control_y, control_local,
    input  din_x, din_y, din_local,
    input  empty_x, empty_y, empty_local,
    input  ready_x, ready_y, ready_local,
    output rd_en_x, rd_en_y, rd_en_local,
    output dout_x, dout_y, dout_local,
    output valid_x, valid_y, valid_local,
    output fail
  );
endinterface

// File: rtl/crossbar_dispatch.sv
// Output side of the router crossbar: each output port pops the input FIFO
// chosen by its select, registers the flit and offers it on a valid/ready
// link. A port stalled for TIMEOUT cycles drops its flit and latches FAILED.
// Index convention for all internal vectors: 0 = x, 1 = y, 2 = local.
module crossbar_dispatch #(
  parameter int DATA_W  = 40,
  parameter int TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               rst_n,   // active-high asynchronous reset
  crossbar_dispatch_if.slave bus
);

  localparam int N = 3;
  localparam logic [7:0] STALL_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_FAILED
  } state_e;

  logic [N-1:0][1:0]        sel;
  logic [N-1:0][DATA_W-1:0] din;
  logic [N-1:0]             empty;
  logic [N-1:0]             ready;

  state_e                   state_q [N];
  state_e                   state_d [N];
  logic [N-1:0][DATA_W-1:0] dout_q, dout_d;
  logic [N-1:0][7:0]        cnt_q, cnt_d;

  logic [N-1:0]             free;
  logic [N-1:0][N-1:0]      gnt;     // gnt[output][input]
  logic [N-1:0]             taken;   // input popped this cycle
  logic [N-1:0]             valid;
  logic [N-1:0]             failed;

  assign sel   = {bus.control_local, bus.control_y, bus.control_x};
  assign din   = {bus.din_local, bus.din_y, bus.din_x};
  assign empty = {bus.empty_local, bus.empty_y, bus.empty_x};
  assign ready = {bus.ready_local, bus.ready_y, bus.ready_x};

  // Request and fixed-priority grant: x, then y, then local claim inputs.
  always_comb begin
    // NOTE: every combinationally written variable gets a default before any
    // conditional assignment; otherwise a path that skips it infers a latch.
    free  = '0;
    gnt   = '0;
    taken = '0;
    for (int o = 0; o < N; o++) begin
      free[o] = (state_q[o] == S_IDLE) || (state_q[o] == S_SEND && ready[o]);
      for (int i = 0; i < N; i++) begin
        if (free[o] && sel[o] == 2'(i + 1) && !empty[i] && !taken[i]) begin
          gnt[o][i] = 1'b1;
          taken[i]  = 1'b1;
        end
      end
    end
  end

  // Per-port FSM next state, flit load and stall counter.
  always_comb begin
    logic [DATA_W-1:0] load;
    for (int o = 0; o < N; o++) begin
      state_d[o] = state_q[o];
      dout_d[o]  = dout_q[o];
      cnt_d[o]   = cnt_q[o];
      load       = '0;
      for (int i = 0; i < N; i++) begin
        if (gnt[o][i]) load = din[i];
      end
      unique case (state_q[o])
        S_IDLE: begin
          if (|gnt[o]) begin
            state_d[o] = S_SEND;
            dout_d[o]  = load;
          end
        end
        S_SEND: begin
          if (ready[o]) begin
            cnt_d[o] = '0;
            if (|gnt[o]) dout_d[o]  = load;    // back-to-back reload
            else         state_d[o] = S_IDLE;
          end else if (cnt_q[o] == STALL_LAST) begin
            state_d[o] = S_FAILED;             // flit is dropped
            dout_d[o]  = '0;
            cnt_d[o]   = '0;
          end else begin
            cnt_d[o] = cnt_q[o] + 8'd1;
          end
        end
        S_FAILED: begin
          // Terminal until reset.
        end
        default: begin
          state_d[o] = S_IDLE;
          cnt_d[o]   = '0;
        end
      endcase
    end
  end

  // Port state, output flit and stall counter registers.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      // NOTE: the output flit registers are reset too (not left as don't-care
      // storage) because dout must read zero whenever reset is asserted.
      for (int o = 0; o < N; o++) begin
        state_q[o] <= S_IDLE;
        dout_q[o]  <= '0;
        cnt_q[o]   <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values computed by the combinational blocks.
      for (int o = 0; o < N; o++) begin
        state_q[o] <= state_d[o];
        dout_q[o]  <= dout_d[o];
        cnt_q[o]   <= cnt_d[o];
      end
    end
  end

  // Status decode; FIFO pops are suppressed while reset is held.
  always_comb begin
    for (int o = 0; o < N; o++) begin
      valid[o]  = (state_q[o] == S_SEND);
      failed[o] = (state_q[o] == S_FAILED);
    end
  end

  assign bus.rd_en_x     = taken[0] & ~rst_n;
  assign bus.rd_en_y     = taken[1] & ~rst_n;
  assign bus.rd_en_local = taken[2] & ~rst_n;

  assign bus.dout_x      = dout_q[0];
  assign bus.dout_y      = dout_q[1];
  assign bus.dout_local  = dout_q[2];

  assign bus.valid_x     = valid[0];
  assign bus.valid_y     = valid[1];
  assign bus.valid_local = valid[2];

  assign bus.fail        = failed;

endmodule

// File: tb/tb_crossbar_dispatch.sv
// Directed bench for crossbar_dispatch: reset, single route, streaming,
// grant conflict, backpressure, stall timeout and reset mid-transfer.
// Vectors are packed {local, y, x}.
module tb_crossbar_dispatch;

  localparam int DATA_W  = 40;
  localparam int TIMEOUT = 16;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  crossbar_dispatch_if #(.DATA_W(DATA_W)) bus ();

  crossbar_dispatch #(
    .DATA_W (DATA_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  logic [2:0] rd_v;
  logic [2:0] vld_v;
  assign rd_v  = {bus.rd_en_local, bus.rd_en_y, bus.rd_en_x};
  assign vld_v = {bus.valid_local, bus.valid_y, bus.valid_x};

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.control_x     = 2'b00;
    bus.control_y     = 2'b00;
    bus.control_local = 2'b00;
    bus.din_x         = '0;
    bus.din_y         = '0;
    bus.din_local     = '0;
    bus.empty_x       = 1'b1;
    bus.empty_y       = 1'b1;
    bus.empty_local   = 1'b1;
    bus.ready_x       = 1'b1;
    bus.ready_y       = 1'b1;
    bus.ready_local   = 1'b1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    clk   = 1'b0;
    rst_n = 1'b1;
    idle_inputs();

    // ---- Reset: a pending request must not pop while reset is high ----
    bus.control_y = 2'b01;
    bus.din_x     = 40'h11;
    bus.empty_x   = 1'b0;
    #1;
    check("rst_rd_en_async", rd_v, 3'b000);
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", vld_v, 3'b000);
    check("rst_fail", bus.fail, 3'b000);
    check("rst_dout_y", bus.dout_y, 40'h0);
    check("rst_rd_en", rd_v, 3'b000);
    idle_inputs();
    rst_n = 1'b0;

    // ---- Single route: y <- x ----
    step();
    bus.control_y = 2'b01;
    bus.din_x     = 40'h00_0000_00A5;
    bus.empty_x   = 1'b0;
    #1;
    check("route_rd_en", rd_v, 3'b001);
    step();
    check("route_valid", vld_v, 3'b010);
    check("route_dout_y", bus.dout_y, 40'hA5);
    bus.control_y = 2'b00;
    bus.empty_x   = 1'b1;
    #1;
    check("route_rd_idle", rd_v, 3'b000);
    step();
    check("route_drain", vld_v, 3'b000);

    // ---- Streaming: x <- local, four flits back to back ----
    bus.control_x   = 2'b11;
    bus.empty_local = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      bus.din_local = 40'(k);
      #1;
      check("stream_rd_en", rd_v, 3'b100);
      step();
      check("stream_valid", vld_v, 3'b001);
      check("stream_dout_x", bus.dout_x, 64'(k));
    end
    bus.empty_local = 1'b1;
    #1;
    check("stream_rd_empty", rd_v, 3'b000);
    step();
    check("stream_end", vld_v, 3'b000);
    bus.control_x = 2'b00;

    // ---- Conflict: x and local both select y; x wins ----
    bus.control_x     = 2'b10;
    bus.control_local = 2'b10;
    bus.din_y         = 40'h77;
    bus.empty_y       = 1'b0;
    #1;
    check("conf_rd_en", rd_v, 3'b010);
    step();
    check("conf_valid", vld_v, 3'b001);
    check("conf_dout_x", bus.dout_x, 40'h77);
    idle_inputs();
    #1;
    check("conf_rd_single", rd_v, 3'b000);
    step();
    check("conf_drain", vld_v, 3'b000);

    // ---- Backpressure on y while x holds another flit ----
    bus.control_y = 2'b01;
    bus.din_x     = 40'h3C;
    bus.empty_x   = 1'b0;
    step();
    check("bp_load", bus.dout_y, 40'h3C);
    bus.ready_y = 1'b0;
    bus.din_x   = 40'h55;
    for (int k = 0; k < 5; k++) begin
      #1;
      check("bp_rd_hold", rd_v, 3'b000);
      step();
      check("bp_valid", vld_v, 3'b010);
      check("bp_dout_y", bus.dout_y, 40'h3C);
    end
    bus.ready_y = 1'b1;
    #1;
    check("bp_rd_release", rd_v, 3'b001);
    step();
    check("bp_next_dout", bus.dout_y, 40'h55);
    check("bp_next_valid", vld_v, 3'b010);
    idle_inputs();
    step();
    check("bp_drain", vld_v, 3'b000);
    check("bp_no_fail", bus.fail, 3'b000);

    // ---- Timeout on local ----
    bus.control_local = 2'b01;
    bus.din_x         = 40'hC1;
    bus.empty_x       = 1'b0;
    bus.ready_local   = 1'b0;
    #1;
    check("to_rd_en", rd_v, 3'b001);
    step();  // edge 0: valid_local rises
    check("to_valid_rise", vld_v, 3'b100);
    bus.control_local = 2'b00;
    bus.empty_x       = 1'b1;
    for (int k = 1; k < TIMEOUT; k++) begin
      step();
      check("to_stall_valid", vld_v, 3'b100);
      check("to_stall_fail", bus.fail, 3'b000);
    end
    step();  // edge TIMEOUT
    check("to_fail", bus.fail, 3'b100);
    check("to_valid_drop", vld_v, 3'b000);
    check("to_dout_zero", bus.dout_local, 40'h0);

    // Failed local ignores its select; x and y keep forwarding.
    bus.control_local = 2'b01;
    bus.din_x         = 40'hD2;
    bus.empty_x       = 1'b0;
    bus.ready_local   = 1'b1;
    bus.control_x     = 2'b10;
    bus.din_y         = 40'hE3;
    bus.empty_y       = 1'b0;
    #1;
    check("fail_rd_en", rd_v, 3'b010);
    step();
    check("fail_x_valid", vld_v, 3'b001);
    check("fail_x_dout", bus.dout_x, 40'hE3);
    check("fail_sticky", bus.fail, 3'b100);
    bus.control_y = 2'b01;
    #1;
    check("fail_rd_both", rd_v, 3'b011);
    step();
    check("fail_xy_valid", vld_v, 3'b011);
    check("fail_y_dout", bus.dout_y, 40'hD2);
    idle_inputs();
    step();
    check("fail_drain", vld_v, 3'b000);

    // ---- Reset mid-transfer with valid_y held ----
    bus.control_y = 2'b01;
    bus.din_x     = 40'h99;
    bus.empty_x   = 1'b0;
    bus.ready_y   = 1'b0;
    step();
    check("mid_valid_y", vld_v, 3'b010);
    bus.control_x = 2'b10;
    bus.din_y     = 40'h42;
    bus.empty_y   = 1'b0;
    #1;
    check("mid_rd_pre", rd_v, 3'b010);
    #1;
    rst_n = 1'b1;
    #1;
    check("mid_rst_valid", vld_v, 3'b000);
    check("mid_rst_dout_y", bus.dout_y, 40'h0);
    check("mid_rst_fail", bus.fail, 3'b000);
    check("mid_rst_rd_en", rd_v, 3'b000);
    idle_inputs();
    step();
    rst_n = 1'b0;
    step();
    check("post_rst_valid", vld_v, 3'b000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
